tl_cntr_timed: RTL and testbench
================================

Name: tl_cntr_timed

Overview:
Parametrised two-road traffic light controller with protected left-turn phases. It adds per-phase duration timers, sensor-driven green extension bounded by minimum and maximum times, and skipping of an unrequested left-turn phase. It drives the La/Lb lamp encodings used by the existing light driver and display blocks in the traffic controller subsystem.

Parameters:
TW, 8, timer width in bits.
MIN_GREEN, 4, minimum green duration in cycles; must be at least 1.
MAX_GREEN, 16, maximum green duration in cycles; must be at least MIN_GREEN.
YELLOW_TIME, 2, yellow duration in cycles; must be at least 1.
MAX_LEFT, 8, maximum left-turn duration in cycles; must be at least 1.
ALL_RED_TIME, 1, all-red clearance duration in cycles. Used only with TL_ALL_RED_EN; must be at least 1.
Every duration parameter is less than 2^TW.

Ports:
clk  input  1  system clock, all state changes on rising edge
reset_n  input  1  asynchronous active-low reset
Ta  input  1  through traffic present on road A
Tal  input  1  left-turn traffic waiting on road A
Tb  input  1  through traffic present on road B
Tbl  input  1  left-turn traffic waiting on road B
La  output  2  road A lamp: GREEN=00, YELLOW=01, LEFT=10, RED=11
Lb  output  2  road B lamp, same encoding
phase  output  4  current state code, for debug and monitoring

Interface (already decided): one clock, clk; reset_n is asynchronous and active-low.

Behaviour:
- States and lamp outputs (La/Lb):
  - AG: GREEN/RED
  - AY1: YELLOW/RED
  - AL: LEFT/RED
  - AY2: YELLOW/RED
  - BG: RED/GREEN
  - BY1: RED/YELLOW
  - BL: RED/LEFT
  - BY2: RED/YELLOW
  - AR and BR (all-red): RED/RED, present only with the optional feature.
- Outputs are a Moore decode of the state register only. phase equals the state code.
- Reset: while reset_n=0, the state is AG, the timer is 0, La=GREEN, Lb=RED and phase=0. Reset asserted mid-phase takes effect immediately, with no clock needed.
- Timer:
  - Clears to 0 on the first cycle of every state.
  - Increments by 1 each cycle after that.
  - Saturates at 2^TW-1 and never wraps.
- All exit conditions are evaluated on the current cycle; the new state is taken at the next rising edge.
- AG exits to AY1 when (timer >= MIN_GREEN-1 and Ta=0) or timer == MAX_GREEN-1. MAX_GREEN overrides a held Ta.
- AY1 exits when timer == YELLOW_TIME-1:
  - to AL if Tal=1;
  - otherwise skips the left phase and goes to BG (to AR if TL_ALL_RED_EN).
- AL exits to AY2 when Tal=0 or timer == MAX_LEFT-1. AL lasts at least 1 cycle.
- AY2 exits to BG (to AR if TL_ALL_RED_EN) when timer == YELLOW_TIME-1.
- Road B mirrors road A: BG, BY1, BL, BY2 use Tb and Tbl and return to AG (to BR if TL_ALL_RED_EN).
- Sensor changes inside yellow or all-red states are ignored. Only the value at the final yellow cycle decides whether the left phase is taken.
- Simultaneous demand (Ta and Tb both 1): road A holds until MAX_GREEN, then hands over. This rule prevents starvation.
- An unreachable state code recovers to AG on the next edge, with outputs RED/RED during that cycle.

Optional Feature:
- Macro TL_ALL_RED_EN.
- When defined:
  - Adds state AR between road A's last yellow (AY1 or AY2) and BG.
  - Adds state BR between road B's last yellow (BY1 or BY2) and AG.
  - Each lasts ALL_RED_TIME cycles with La=Lb=RED.
- When undefined: those states, their codes' decode and the ALL_RED_TIME logic are absent. Yellow goes directly to the opposite green.

Decomposition:
- Package tl_pkg holds:
  - the lamp colour constants GREEN, YELLOW, LEFT, RED;
  - the 4-bit state codes: AG=0, AY1=1, AL=2, AY2=3, BG=4, BY1=5, BL=6, BY2=7, AR=8, BR=9.
- One sub-module, tl_phase_timer:
  - TW-bit counter with synchronous clear-on-state-change and saturation;
  - asynchronous reset on reset_n.
- The FSM and output decode remain in tl_cntr_timed.

Test Plan (default parameters, feature off unless stated):
- Reset, then all sensors 0:
  - AG 4 cycles, AY1 2, BG 4, BY1 2, then AG again; 12-cycle period;
  - AL and BL never entered.
- Ta=1 held, others 0: AG lasts exactly 16 cycles, then AY1 with La=01.
- Tal=1 at the final AY1 cycle and held: AL lasts 8 cycles with La=10, Lb=11, then AY2 2 cycles, then BG.
- Tal pulsed for only the final AY1 cycle: AL lasts 1 cycle, then AY2.
- reset_n driven low during BL, mid-timer: La=00, Lb=11, phase=0 asynchronously; the full AG minimum of 4 cycles is honoured after release.
- TL_ALL_RED_EN defined, all sensors 0:
  - BY1 followed by 1 cycle of La=Lb=11 with phase=9, then AG;
  - period is 14 cycles.

Source files
------------

// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared constants for the timed two-road traffic light controller.
//   - Lamp colour encodings driven onto La/Lb (understood by the light driver
//     and display blocks downstream).
//   - 4-bit state codes, also exported unchanged on the phase debug port.
// AR/BR codes are reserved here unconditionally; they are only decoded when
// the controller is built with TL_ALL_RED_EN.
// -----------------------------------------------------------------------------
package tl_pkg;

    typedef logic [1:0] lamp_t;
    typedef logic [3:0] state_t;

    // Lamp colours
    localparam lamp_t GREEN  = 2'b00;
    localparam lamp_t YELLOW = 2'b01;
    localparam lamp_t LEFT   = 2'b10;
    localparam lamp_t RED    = 2'b11;

    // State codes
    localparam state_t AG  = 4'd0;
    localparam state_t AY1 = 4'd1;
    localparam state_t AL  = 4'd2;
    localparam state_t AY2 = 4'd3;
    localparam state_t BG  = 4'd4;
    localparam state_t BY1 = 4'd5;
    localparam state_t BL  = 4'd6;
    localparam state_t BY2 = 4'd7;
    localparam state_t AR  = 4'd8;
    localparam state_t BR  = 4'd9;

endpackage

// File: rtl/tl_phase_timer.sv
// -----------------------------------------------------------------------------
// tl_phase_timer
// Per-phase duration counter. Reads 0 on the first cycle of every state,
// counts up by one each following cycle and holds at all-ones instead of
// wrapping, so a long phase can never alias back to a short timer value.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset (timer -> 0)
//   clr      state is changing at the next edge; restart the count from 0
//   timer    current phase age in cycles (TW bits)
// -----------------------------------------------------------------------------
module tl_phase_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    output logic [TW-1:0] timer
);

    logic [TW-1:0] timer_r;

    // Phase age counter: clear on state change, otherwise saturating increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_r <= {TW{1'b0}};
        end else if (clr) begin
            timer_r <= {TW{1'b0}};
        end else if (timer_r != {TW{1'b1}}) begin
            timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            timer_r <= timer_r;
        end
    end

    assign timer = timer_r;

endmodule

// File: rtl/tl_cntr_timed.sv
// -----------------------------------------------------------------------------
// tl_cntr_timed
// Two-road traffic light controller with protected left-turn phases,
// per-phase timers, sensor-driven green extension bounded by MIN_GREEN /
// MAX_GREEN, and skipping of an unrequested left-turn phase.
//
// Phase cycle: AG -> AY1 -> [AL -> AY2] -> BG -> BY1 -> [BL -> BY2] -> AG
// With TL_ALL_RED_EN defined, an all-red clearance state (AR / BR) of
// ALL_RED_TIME cycles is inserted before each opposite green. Without the
// macro those states and their decode do not exist.
//
// Ports:
//   clk      system clock, all state changes on rising edge
//   reset_n  asynchronous active-low reset (state AG, timer 0)
//   Ta, Tb   through traffic present on road A / B
//   Tal, Tbl left-turn traffic waiting on road A / B
//   La, Lb   lamp encodings (GREEN=00 YELLOW=01 LEFT=10 RED=11)
//   phase    current state code, for debug and monitoring
//
// Outputs are a pure Moore decode of the state register.
// -----------------------------------------------------------------------------
module tl_cntr_timed
    import tl_pkg::*;
#(
    parameter int TW           = 8,
    parameter int MIN_GREEN    = 4,
    parameter int MAX_GREEN    = 16,
    parameter int YELLOW_TIME  = 2,
    parameter int MAX_LEFT     = 8,
    parameter int ALL_RED_TIME = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ta,
    input  logic       Tal,
    input  logic       Tb,
    input  logic       Tbl,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [3:0] phase
);

    // Elaboration-time guard on parameter legality
    if ((MIN_GREEN < 1) || (MAX_GREEN < MIN_GREEN) || (YELLOW_TIME < 1) ||
        (MAX_LEFT < 1) || (ALL_RED_TIME < 1) || (MAX_GREEN >= (2**TW)) ||
        (YELLOW_TIME >= (2**TW)) || (MAX_LEFT >= (2**TW)) ||
        (ALL_RED_TIME >= (2**TW))) begin : g_param_err
        $error("tl_cntr_timed: illegal duration parameters for TW=%0d", TW);
    end

    // Exit thresholds expressed as "last cycle" timer values
    localparam logic [TW-1:0] MIN_G_LAST = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_G_LAST = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_LAST   = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] LEFT_LAST  = TW'(MAX_LEFT - 1);

`ifdef TL_ALL_RED_EN
    localparam logic [TW-1:0] RED_LAST   = TW'(ALL_RED_TIME - 1);
    // Road A's last yellow hands over through AR, road B's through BR
    localparam state_t A_HANDOFF = AR;
    localparam state_t B_HANDOFF = BR;
`else
    localparam state_t A_HANDOFF = BG;
    localparam state_t B_HANDOFF = AG;
`endif

    state_t        state_r;
    state_t        next_s;
    logic [TW-1:0] timer_s;
    logic          state_chg_s;
    lamp_t         la_s;
    lamp_t         lb_s;

    // The timer restarts whenever the next edge moves us to a new state
    assign state_chg_s = (next_s != state_r);

    tl_phase_timer #(
        .TW(TW)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state_chg_s),
        .timer   (timer_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= AG;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; every exit is judged on the current cycle's inputs.
    // Green ends on (min reached and no demand) or max reached, so a held
    // demand on one road can never starve the other.
    always_comb begin
        next_s = state_r;
        case (state_r)
            AG: begin
                if (((timer_s >= MIN_G_LAST) && !Ta) || (timer_s == MAX_G_LAST)) begin
                    next_s = AY1;
                end else begin
                    next_s = AG;
                end
            end
            AY1: begin
                // Only the left-turn request on the final yellow cycle counts
                if (timer_s == YEL_LAST) begin
                    if (Tal) begin
                        next_s = AL;
                    end else begin
                        next_s = A_HANDOFF;
                    end
                end else begin
                    next_s = AY1;
                end
            end
            AL: begin
                if (!Tal || (timer_s == LEFT_LAST)) begin
                    next_s = AY2;
                end else begin
                    next_s = AL;
                end
            end
            AY2: begin
                if (timer_s == YEL_LAST) begin
                    next_s = A_HANDOFF;
                end else begin
                    next_s = AY2;
                end
            end
            BG: begin
                if (((timer_s >= MIN_G_LAST) && !Tb) || (timer_s == MAX_G_LAST)) begin
                    next_s = BY1;
                end else begin
                    next_s = BG;
                end
            end
            BY1: begin
                if (timer_s == YEL_LAST) begin
                    if (Tbl) begin
                        next_s = BL;
                    end else begin
                        next_s = B_HANDOFF;
                    end
                end else begin
                    next_s = BY1;
                end
            end
            BL: begin
                if (!Tbl || (timer_s == LEFT_LAST)) begin
                    next_s = BY2;
                end else begin
                    next_s = BL;
                end
            end
            BY2: begin
                if (timer_s == YEL_LAST) begin
                    next_s = B_HANDOFF;
                end else begin
                    next_s = BY2;
                end
            end
`ifdef TL_ALL_RED_EN
            AR: begin
                if (timer_s == RED_LAST) begin
                    next_s = BG;
                end else begin
                    next_s = AR;
                end
            end
            BR: begin
                if (timer_s == RED_LAST) begin
                    next_s = AG;
                end else begin
                    next_s = BR;
                end
            end
`endif
            default: begin
                // Unreachable code: recover to road A green at the next edge
                next_s = AG;
            end
        endcase
    end

    // Moore lamp decode; unknown codes show all-red until recovery
    always_comb begin
        la_s = RED;
        lb_s = RED;
        case (state_r)
            AG:  begin la_s = GREEN;  lb_s = RED;    end
            AY1: begin la_s = YELLOW; lb_s = RED;    end
            AL:  begin la_s = LEFT;   lb_s = RED;    end
            AY2: begin la_s = YELLOW; lb_s = RED;    end
            BG:  begin la_s = RED;    lb_s = GREEN;  end
            BY1: begin la_s = RED;    lb_s = YELLOW; end
            BL:  begin la_s = RED;    lb_s = LEFT;   end
            BY2: begin la_s = RED;    lb_s = YELLOW; end
`ifdef TL_ALL_RED_EN
            AR:  begin la_s = RED;    lb_s = RED;    end
            BR:  begin la_s = RED;    lb_s = RED;    end
`endif
            default: begin la_s = RED; lb_s = RED; end
        endcase
    end

    assign La    = la_s;
    assign Lb    = lb_s;
    assign phase = state_r;

endmodule

// File: tb/tb_tl_cntr_timed.sv
// -----------------------------------------------------------------------------
// tb_tl_cntr_timed
// Directed, table-driven bench for tl_cntr_timed at default parameters.
// Each table row holds the sensor inputs for one clock cycle and the
// expected phase code / lamps during that cycle. A hand-written sequence
// covers asynchronous reset in the middle of a left-turn phase.
// All-red expectations follow TL_ALL_RED_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_tl_cntr_timed;

    typedef struct {
        logic       ta;
        logic       tal;
        logic       tb;
        logic       tbl;
        logic [3:0] ph;
        logic [1:0] la;
        logic [1:0] lb;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic       Ta;
    logic       Tal;
    logic       Tb;
    logic       Tbl;
    logic [1:0] La;
    logic [1:0] Lb;
    logic [3:0] phase;

    int n_checks;
    int n_fail;

    vec_t vq[$];
    vec_t rq[$];

    tl_cntr_timed dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Ta      (Ta),
        .Tal     (Tal),
        .Tb      (Tb),
        .Tbl     (Tbl),
        .La      (La),
        .Lb      (Lb),
        .phase   (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lamp colours per phase code, straight from the state/lamp table
    function automatic logic [1:0] exp_la(input logic [3:0] ph);
        case (ph)
            4'd0:                return 2'b00;
            4'd1, 4'd3:          return 2'b01;
            4'd2:                return 2'b10;
            default:             return 2'b11;
        endcase
    endfunction

    function automatic logic [1:0] exp_lb(input logic [3:0] ph);
        case (ph)
            4'd4:                return 2'b00;
            4'd5, 4'd7:          return 2'b01;
            4'd6:                return 2'b10;
            default:             return 2'b11;
        endcase
    endfunction

    // Append n identical cycles to a vector queue
    task automatic add(inout vec_t q[$], input int n, input logic ta, input logic tal,
                       input logic tb, input logic tbl, input logic [3:0] ph);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.ta  = ta;
            v.tal = tal;
            v.tb  = tb;
            v.tbl = tbl;
            v.ph  = ph;
            v.la  = exp_la(ph);
            v.lb  = exp_lb(ph);
            q.push_back(v);
        end
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] ph_e,
                         input logic [1:0] la_e, input logic [1:0] lb_e);
        n_checks++;
        if ((phase !== ph_e) || (La !== la_e) || (Lb !== lb_e)) begin
            n_fail++;
            $display("FAIL %s[%0d]: got phase=%0d La=%b Lb=%b, expected phase=%0d La=%b Lb=%b",
                     name, idx, phase, La, Lb, ph_e, la_e, lb_e);
        end
    endtask

    // Apply a table: drive inputs just after the edge, check mid-cycle
    task automatic run(input string name, input vec_t q[$]);
        for (int i = 0; i < q.size(); i++) begin
            Ta  = q[i].ta;
            Tal = q[i].tal;
            Tb  = q[i].tb;
            Tbl = q[i].tbl;
            @(negedge clk);
            check(name, i, q[i].ph, q[i].la, q[i].lb);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        Ta = 1'b0; Tal = 1'b0; Tb = 1'b0; Tbl = 1'b0;

        // ---- Main table ---------------------------------------------------
        // Two idle periods; second one has Tal only on the first AY1 cycle,
        // which must be ignored (left phase skipped).
        add(vq, 4, 0, 0, 0, 0, 4'd0);
        add(vq, 2, 0, 0, 0, 0, 4'd1);
`ifdef TL_ALL_RED_EN
        add(vq, 1, 0, 0, 0, 0, 4'd8);
`endif
        add(vq, 4, 0, 0, 0, 0, 4'd4);
        add(vq, 2, 0, 0, 0, 0, 4'd5);
`ifdef TL_ALL_RED_EN
        add(vq, 1, 0, 0, 0, 0, 4'd9);
`endif
        add(vq, 4, 0, 0, 0, 0, 4'd0);
        add(vq, 1, 0, 1, 0, 0, 4'd1);
        add(vq, 1, 0, 0, 0, 0, 4'd1);
`ifdef TL_ALL_RED_EN
        add(vq, 1, 0, 0, 0, 0, 4'd8);
`endif
        add(vq, 4, 0, 0, 0, 0, 4'd4);
        add(vq, 2, 0, 0, 0, 0, 4'd5);
`ifdef TL_ALL_RED_EN
        add(vq, 1, 0, 0, 0, 0, 4'd9);
`endif
        // Ta held: AG capped at MAX_GREEN=16; Tal raised on final AY1 cycle
        // and held: AL capped at MAX_LEFT=8, then AY2 x2 and BG.
        add(vq, 16, 1, 0, 0, 0, 4'd0);
        add(vq, 1, 0, 0, 0, 0, 4'd1);
        add(vq, 1, 0, 1, 0, 0, 4'd1);
        add(vq, 8, 0, 1, 0, 0, 4'd2);
        add(vq, 2, 0, 1, 0, 0, 4'd3);
`ifdef TL_ALL_RED_EN
        add(vq, 1, 0, 0, 0, 0, 4'd8);
`endif
        // Tbl pulsed on final BY1 cycle only: BL for 1 cycle, then BY2
        add(vq, 4, 0, 0, 0, 0, 4'd4);
        add(vq, 1, 0, 0, 0, 0, 4'd5);
        add(vq, 1, 0, 0, 0, 1, 4'd5);
        add(vq, 1, 0, 0, 0, 0, 4'd6);
        add(vq, 2, 0, 0, 0, 0, 4'd7);
`ifdef TL_ALL_RED_EN
        add(vq, 1, 0, 0, 0, 0, 4'd9);
`endif
        // Tal pulsed on final AY1 cycle only: AL for 1 cycle
        add(vq, 4, 0, 0, 0, 0, 4'd0);
        add(vq, 1, 0, 0, 0, 0, 4'd1);
        add(vq, 1, 0, 1, 0, 0, 4'd1);
        add(vq, 1, 0, 0, 0, 0, 4'd2);
        add(vq, 2, 0, 0, 0, 0, 4'd3);
`ifdef TL_ALL_RED_EN
        add(vq, 1, 0, 0, 0, 0, 4'd8);
`endif
        // Simultaneous demand: BG holds to MAX_GREEN, then BY1; Tbl held
        // into BL so the reset sequence below lands mid-left-turn.
        add(vq, 16, 1, 0, 1, 0, 4'd4);
        add(vq, 1, 1, 0, 1, 0, 4'd5);
        add(vq, 1, 1, 0, 1, 1, 4'd5);
        add(vq, 3, 0, 0, 0, 1, 4'd6);

        // ---- After reset release: full AG minimum, then AY1 -------------
        add(rq, 4, 0, 0, 0, 0, 4'd0);
        add(rq, 2, 0, 0, 0, 0, 4'd1);
`ifdef TL_ALL_RED_EN
        add(rq, 1, 0, 0, 0, 0, 4'd8);
`endif
        add(rq, 1, 0, 0, 0, 0, 4'd4);

        // ---- Reset state --------------------------------------------------
        @(negedge clk);
        check("reset", 0, 4'd0, 2'b00, 2'b11);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        run("main", vq);

        // ---- Asynchronous reset during BL (timer at 3, Tbl still held) ----
        Tbl = 1'b1;
        #1;
        check("bl_before_rst", 0, 4'd6, 2'b11, 2'b10);
        #1;
        reset_n = 1'b0;
        #1;
        // No clock edge has happened since reset was asserted
        check("async_rst", 0, 4'd0, 2'b00, 2'b11);
        Tbl = 1'b0;
        @(posedge clk);
        #1;
        check("rst_held", 0, 4'd0, 2'b00, 2'b11);
        reset_n = 1'b1;

        run("post_rst", rq);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
